// File: rtl/fault_inj_pkg.sv
// Shared types and constants for the OS-array fault-injection controller.
`default_nettype none

package fault_inj_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    WAIT   = 3'd2,
    INJECT = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic MODE_TIMED = 1'b0;
  localparam logic MODE_PERM  = 1'b1;

  // Which PE operand the array top routes the mask onto.
  localparam logic [1:0] FAULT_TARGET_WEIGHT = 2'd0;
  localparam logic [1:0] FAULT_TARGET_INPUT  = 2'd1;
  localparam logic [1:0] FAULT_TARGET_PSUM   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pe_mask_demux.sv
// Registered one-hot placement of a fault mask onto one PE slice of the bus.
`default_nettype none

module pe_mask_demux #(
  parameter int D_W  = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int RW   = 2,
  parameter int CW   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [RW-1:0]            row_i,
  input  logic [CW-1:0]            col_i,
  input  logic [D_W-1:0]           mask_i,
  output logic [ROWS*COLS*D_W-1:0] bus_o,
  output logic                     active_o
);

  logic [ROWS*COLS*D_W-1:0] bus_d;
  logic [ROWS*COLS*D_W-1:0] bus_q;
  logic                     active_d;
  logic                     active_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign bus_d[(r*COLS+c)*D_W +: D_W] =
        (en_i && (row_i == RW'(r)) && (col_i == CW'(c))) ? mask_i : '0;
    end
  end

  // Only one slice can be selected, so the flag is just enable and nonzero mask.
  assign active_d = en_i && (|mask_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q    <= '0;
      active_q <= 1'b0;
    end else begin
      bus_q    <= bus_d;
      active_q <= active_d;
    end
  end

  assign bus_o    = bus_q;
  assign active_o = active_q;

endmodule

`default_nettype wire

// File: rtl/os_fault_inject_ctrl.sv
// Fault-schedule controller: drives one PE's XOR mask for a window timed from run_start.
`default_nettype none

module os_fault_inject_ctrl
  import fault_inj_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [RW-1:0]            cfg_row,
  input  logic [CW-1:0]            cfg_col,
  input  logic [D_W-1:0]           cfg_mask,
  input  logic [CNT_W-1:0]         cfg_start,
  input  logic [CNT_W-1:0]         cfg_duration,
  input  logic                     cfg_mode,
  output logic                     cfg_err,
  input  logic                     run_start,
  input  logic                     disarm,
  output logic [ROWS*COLS*D_W-1:0] fault_mask_bus,
  output logic                     fault_active,
  output logic                     inj_done,
  output logic [2:0]               state_o
);

  localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);
  localparam logic [CW:0] COLS_L = (CW+1)'(COLS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0]    row_q;
  logic [CW-1:0]    col_q;
  logic [D_W-1:0]   mask_q;
  logic [CNT_W-1:0] start_q, dur_q;
  logic             mode_q;
  logic             done_q, err_q;
  logic             in_range, cfg_take, cfg_bad;
  logic             inj_en, done_d;

  assign in_range = ({1'b0, cfg_row} < ROWS_L) && ({1'b0, cfg_col} < COLS_L);
  assign cfg_take = (state_q == IDLE) && cfg_valid && !disarm && in_range;
  assign cfg_bad  = (state_q == IDLE) && cfg_valid && !disarm && !in_range;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mask_q  <= '0;
      start_q <= '0;
      dur_q   <= '0;
      mode_q  <= MODE_TIMED;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= cfg_bad;
      if (cfg_take) begin
        row_q   <= cfg_row;
        col_q   <= cfg_col;
        mask_q  <= cfg_mask;
        start_q <= cfg_start;
        dur_q   <= cfg_duration;
        mode_q  <= cfg_mode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (disarm) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (cfg_take) state_d = ARMED;
        ARMED: begin
          if (run_start) begin
            cnt_d = '0;
            if (mode_q == MODE_TIMED && dur_q == '0) state_d = DONE;
            else if (start_q == '0)                  state_d = INJECT;
            else                                     state_d = WAIT;
          end
        end
        WAIT: begin
          cnt_d = cnt_inc;
          if (cnt_q == start_q - CNT_W'(1)) begin
            state_d = INJECT;
            cnt_d   = '0;
          end
        end
        INJECT: begin
          cnt_d = cnt_inc;
          if (mode_q == MODE_TIMED && cnt_q == dur_q - CNT_W'(1)) state_d = DONE;
        end
        DONE:    state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs are loaded from the next state so they line up with it.
  always_comb begin
    cfg_ready = (state_q == IDLE);
    state_o   = state_q;
    inj_en    = (state_d == INJECT);
    done_d    = (state_d == DONE);
  end

  pe_mask_demux #(
    .D_W  (D_W),
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_demux (
    .clk      (clk),
    .rst      (rst),
    .en_i     (inj_en),
    .row_i    (row_q),
    .col_i    (col_q),
    .mask_i   (mask_q),
    .bus_o    (fault_mask_bus),
    .active_o (fault_active)
  );

  assign inj_done = done_q;
  assign cfg_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_os_fault_inject_ctrl.sv
// Directed vector bench for os_fault_inject_ctrl (3x4 array so row 3 is out of range).
`timescale 1ns/1ps
`default_nettype none

module tb_os_fault_inject_ctrl;

  localparam int D_W = 8, ROWS = 3, COLS = 4, CNT_W = 16;
  localparam int BW  = ROWS*COLS*D_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid, cfg_ready, cfg_mode, cfg_err;
  logic [1:0]        cfg_row, cfg_col;
  logic [D_W-1:0]    cfg_mask;
  logic [CNT_W-1:0]  cfg_start, cfg_duration;
  logic              run_start, disarm;
  logic [BW-1:0]     fault_mask_bus;
  logic              fault_active, inj_done;
  logic [2:0]        state_o;

  int checks   = 0;
  int failures = 0;

  os_fault_inject_ctrl #(.D_W(D_W), .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_mask(cfg_mask),
    .cfg_start(cfg_start), .cfg_duration(cfg_duration), .cfg_mode(cfg_mode),
    .cfg_err(cfg_err), .run_start(run_start), .disarm(disarm),
    .fault_mask_bus(fault_mask_bus), .fault_active(fault_active),
    .inj_done(inj_done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vld; logic [1:0] row, col; logic [7:0] mask;
    logic [15:0] st, dur; logic mode, rs, dis;
    logic [2:0] e_st; int e_idx; logic [7:0] e_val;
    logic e_act, e_done, e_err, e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vld, logic [1:0] row, logic [1:0] col, logic [7:0] mask,
                              logic [15:0] st, logic [15:0] dur, logic mode, logic rs, logic dis,
                              logic [2:0] e_st, int e_idx, logic [7:0] e_val,
                              logic e_act, logic e_done, logic e_err, logic e_rdy);
    vec_t v;
    v.vld = vld; v.row = row; v.col = col; v.mask = mask; v.st = st; v.dur = dur;
    v.mode = mode; v.rs = rs; v.dis = dis; v.e_st = e_st; v.e_idx = e_idx; v.e_val = e_val;
    v.e_act = e_act; v.e_done = e_done; v.e_err = e_err; v.e_rdy = e_rdy;
    return v;
  endfunction

  function automatic logic [BW-1:0] exp_bus(int idx, logic [7:0] val);
    logic [BW-1:0] b;
    b = '0;
    if (idx >= 0) b[idx*D_W +: D_W] = val;
    return b;
  endfunction

  task automatic chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; cfg_row = 0; cfg_col = 0; cfg_mask = 0; cfg_start = 0;
    cfg_duration = 0; cfg_mode = 0; run_start = 0; disarm = 0;
  endtask

  task automatic write_cfg(logic [1:0] r, logic [1:0] c, logic [7:0] m,
                           logic [15:0] st, logic [15:0] dur, logic mode);
    cfg_valid = 1; cfg_row = r; cfg_col = c; cfg_mask = m;
    cfg_start = st; cfg_duration = dur; cfg_mode = mode;
    step();
    cfg_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) step();
    rst = 0;
    chk("reset state", BW'(state_o), BW'(0));
    chk("reset bus", fault_mask_bus, '0);
    chk("reset active", BW'(fault_active), BW'(0));
    chk("reset done", BW'(inj_done), BW'(0));
    chk("reset err", BW'(cfg_err), BW'(0));
    chk("reset ready", BW'(cfg_ready), BW'(1));

    //            vld row col mask  st dur md rs ds | st idx val act dn er rdy
    vecs.push_back(mk(1, 1, 2, 8'h04, 3, 2, 0, 0, 0,  0, -1, 0,    0, 0, 0, 1)); // c0
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  1, -1, 0,    0, 0, 0, 0)); // c1
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0,  1, -1, 0,    0, 0, 0, 0)); // c2 run
    vecs.push_back(mk(1, 3, 0, 8'hff, 0, 0, 0, 0, 0,  2, -1, 0,    0, 0, 0, 0)); // c3 cfg in WAIT
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  2, -1, 0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  2, -1, 0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  3,  6, 8'h04, 1, 0, 0, 0)); // c6
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  3,  6, 8'h04, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  4, -1, 0,    0, 1, 0, 0)); // c8 done
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0,  1, -1, 0,    0, 0, 0, 0)); // c9 rerun
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  2, -1, 0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0,  2, -1, 0,    0, 0, 0, 0)); // run in WAIT
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  2, -1, 0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  3,  6, 8'h04, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0,  3,  6, 8'h04, 1, 0, 0, 0)); // run in INJECT
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  4, -1, 0,    0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1,  1, -1, 0,    0, 0, 0, 0)); // c16 disarm
    vecs.push_back(mk(1, 3, 0, 8'hff, 0, 0, 0, 0, 0,  0, -1, 0,    0, 0, 0, 1)); // bad row
    vecs.push_back(mk(1, 2, 3, 8'h55, 0, 0, 0, 0, 0,  0, -1, 0,    0, 0, 1, 1)); // dur=0 cfg
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0,  1, -1, 0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  4, -1, 0,    0, 1, 0, 0)); // c20
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1,  1, -1, 0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 3, 8'h55, 0, 1, 0, 1, 0,  0, -1, 0,    0, 0, 0, 1)); // cfg+run
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0,  1, -1, 0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  3, 11, 8'h55, 1, 0, 0, 0)); // c24
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  4, -1, 0,    0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1,  1, -1, 0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  0, -1, 0,    0, 0, 0, 1)); // c27

    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("v%0d state", i), BW'(state_o), BW'(vecs[i].e_st));
      chk($sformatf("v%0d bus", i), fault_mask_bus, exp_bus(vecs[i].e_idx, vecs[i].e_val));
      chk($sformatf("v%0d active", i), BW'(fault_active), BW'(vecs[i].e_act));
      chk($sformatf("v%0d done", i), BW'(inj_done), BW'(vecs[i].e_done));
      chk($sformatf("v%0d err", i), BW'(cfg_err), BW'(vecs[i].e_err));
      chk($sformatf("v%0d ready", i), BW'(cfg_ready), BW'(vecs[i].e_rdy));
      cfg_valid = vecs[i].vld; cfg_row = vecs[i].row; cfg_col = vecs[i].col;
      cfg_mask = vecs[i].mask; cfg_start = vecs[i].st; cfg_duration = vecs[i].dur;
      cfg_mode = vecs[i].mode; run_start = vecs[i].rs; disarm = vecs[i].dis;
      step();
    end
    idle_inputs();

    // Permanent mode: PE(0,1), start 2, held until disarm 20 cycles after run.
    write_cfg(0, 1, 8'h80, 2, 0, 1);
    run_start = 1; step(); run_start = 0;
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("perm k%0d bus", k), fault_mask_bus,
          (k < 3) ? exp_bus(-1, 0) : exp_bus(1, 8'h80));
      chk($sformatf("perm k%0d done", k), BW'(inj_done), BW'(0));
      if (k == 20) disarm = 1;
      step();
    end
    disarm = 0;
    chk("perm disarm bus", fault_mask_bus, '0);
    chk("perm disarm done", BW'(inj_done), BW'(0));
    chk("perm disarm state", BW'(state_o), BW'(0));

    // Zero mask still walks the FSM but never raises fault_active.
    write_cfg(1, 1, 8'h00, 0, 0, 1);
    run_start = 1; step(); run_start = 0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("zero k%0d state", k), BW'(state_o), BW'(3));
      chk($sformatf("zero k%0d active", k), BW'(fault_active), BW'(0));
      chk($sformatf("zero k%0d bus", k), fault_mask_bus, '0);
      step();
    end
    disarm = 1; step(); disarm = 0;

    // Reset in the middle of an injection window.
    write_cfg(2, 0, 8'h11, 1, 5, 0);
    run_start = 1; step();
    step(); run_start = 0;
    chk("rst pre bus", fault_mask_bus, exp_bus(8, 8'h11));
    chk("rst pre state", BW'(state_o), BW'(3));
    rst = 1; step(); rst = 0;
    chk("rst post bus", fault_mask_bus, '0);
    chk("rst post active", BW'(fault_active), BW'(0));
    chk("rst post state", BW'(state_o), BW'(0));
    chk("rst post ready", BW'(cfg_ready), BW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
